// File: rtl/prg_ray_ingress_if.sv
// -----------------------------------------------------------------------------
// prg_ray_ingress_if
// Bundles the ray-ingress block's streaming links:
//   prg_to_shader_*  : primary rays arriving from the ray generator
//                      (valid/stall, data = {pixelID, origin xyz, dir xyz})
//   trav_*           : {rayID, origin, dir} leaving towards traversal
//   retire_*         : ray-finished notifications carrying the ray ID
//   pixel_*          : pixel ID looked up for each retired ray
// Modports:
//   slave  : the ingress block itself
//   master : the surrounding environment (generator, traversal, retire source)
// -----------------------------------------------------------------------------
interface prg_ray_ingress_if #(
    parameter int RID_W = 6,
    parameter int PIX_W = 19
);
    localparam int GEOM_W = 192;
    localparam int RAY_W  = PIX_W + GEOM_W;
    localparam int TRAV_W = GEOM_W + RID_W;

    logic              prg_to_shader_valid;
    logic [RAY_W-1:0]  prg_to_shader_data;
    logic              prg_to_shader_stall;

    logic              trav_valid;
    logic [TRAV_W-1:0] trav_data;
    logic              trav_stall;

    logic              retire_valid;
    logic [RID_W-1:0]  retire_rayID;

    logic              pixel_valid;
    logic [PIX_W-1:0]  pixel_id;

    modport slave (
        input  prg_to_shader_valid, prg_to_shader_data, trav_stall,
               retire_valid, retire_rayID,
        output prg_to_shader_stall, trav_valid, trav_data,
               pixel_valid, pixel_id
    );

    modport master (
        output prg_to_shader_valid, prg_to_shader_data, trav_stall,
               retire_valid, retire_rayID,
        input  prg_to_shader_stall, trav_valid, trav_data,
               pixel_valid, pixel_id
    );
endinterface

// File: rtl/prg_ray_ingress.sv
// -----------------------------------------------------------------------------
// prg_ray_ingress
// Shader-side receiver for primary rays. Each accepted ray is given a ray ID
// from a free list, its pixel ID is stored in a table indexed by that ray ID,
// and {rayID, origin, dir} is queued in a small output FIFO for traversal.
// When a ray retires, its pixel ID is returned and the ray ID is recycled.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : prg_to_shader valid/data/stall, trav valid/data/stall,
//                      retire valid/rayID, pixel valid/id
//   num_outstanding  : number of ray IDs currently allocated
//   err              : sticky flag, set when a non-allocated ID is retired
// -----------------------------------------------------------------------------
module prg_ray_ingress #(
    parameter int NUM_RAYS  = 64,
    parameter int RID_W     = $clog2(NUM_RAYS),
    parameter int PIX_W     = 19,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    prg_ray_ingress_if.slave bus,
    output logic [RID_W:0]   num_outstanding,
    output logic             err
);
    localparam int GEOM_W = 192;
    localparam int TRAV_W = GEOM_W + RID_W;
    localparam int OPTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [OCNT_W-1:0] OUT_FULL  = OCNT_W'(OUT_DEPTH);
    localparam logic [OPTR_W-1:0] OPTR_LAST = OPTR_W'(OUT_DEPTH - 1);

    // Fresh-ID counter: its MSB sets once all NUM_RAYS IDs have been handed out.
    logic [RID_W:0]    init_cnt_q, init_cnt_d;

    // Recycle FIFO; NUM_RAYS deep, so it can never overflow (IDs are unique).
    logic [RID_W-1:0]  rec_mem_q [NUM_RAYS];
    logic [RID_W-1:0]  rec_rd_q, rec_rd_d;
    logic [RID_W-1:0]  rec_wr_q, rec_wr_d;
    logic [RID_W:0]    rec_cnt_q, rec_cnt_d;

    // Output FIFO towards traversal.
    logic [TRAV_W-1:0] out_mem_q [OUT_DEPTH];
    logic [OPTR_W-1:0] out_rd_q, out_rd_d;
    logic [OPTR_W-1:0] out_wr_q, out_wr_d;
    logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;

    // Ray-info table: pixel ID per ray ID (contents survive reset).
    logic [PIX_W-1:0]  tbl_q [NUM_RAYS];

    logic [NUM_RAYS-1:0] busy_q, busy_d;
    logic [RID_W:0]      nout_q, nout_d;
    logic                err_q, err_d;
    logic                pix_vld_q, pix_vld_d;
    logic [PIX_W-1:0]    pix_id_q, pix_id_d;

    logic              fresh;
    logic              free_empty;
    logic              stall;
    logic              xfer;
    logic              out_pop;
    logic              ret_ok;
    logic              ret_bad;
    logic [RID_W-1:0]  alloc_id;

    // Stall is derived only from registered state, so there is no
    // combinational path from any input to prg_to_shader_stall.
    always_comb begin
        fresh      = ~init_cnt_q[RID_W];
        free_empty = ~fresh && (rec_cnt_q == '0);
        stall      = free_empty || (out_cnt_q == OUT_FULL);
        xfer       = bus.prg_to_shader_valid && ~stall;
        out_pop    = (out_cnt_q != '0) && ~bus.trav_stall;
        ret_ok     = bus.retire_valid &&  busy_q[bus.retire_rayID];
        ret_bad    = bus.retire_valid && ~busy_q[bus.retire_rayID];
        alloc_id   = fresh ? init_cnt_q[RID_W-1:0] : rec_mem_q[rec_rd_q];
    end

    always_comb begin
        init_cnt_d = init_cnt_q;
        rec_rd_d   = rec_rd_q;
        rec_wr_d   = rec_wr_q;
        rec_cnt_d  = rec_cnt_q;
        out_rd_d   = out_rd_q;
        out_wr_d   = out_wr_q;
        out_cnt_d  = out_cnt_q;
        busy_d     = busy_q;
        nout_d     = nout_q;
        err_d      = err_q | ret_bad;
        pix_vld_d  = ret_ok;
        pix_id_d   = pix_id_q;

        // Allocation: fresh IDs take priority until the counter is exhausted.
        if (xfer) begin
            if (fresh) begin
                init_cnt_d = init_cnt_q + 1'b1;
            end else begin
                rec_rd_d = rec_rd_q + 1'b1;
            end
            out_wr_d         = (out_wr_q == OPTR_LAST) ? '0 : out_wr_q + 1'b1;
            busy_d[alloc_id] = 1'b1;
        end

        if (out_pop) begin
            out_rd_d = (out_rd_q == OPTR_LAST) ? '0 : out_rd_q + 1'b1;
        end

        // A retiring ID is always distinct from the one allocated this cycle,
        // because its busy bit was already set; so set and clear cannot collide.
        if (ret_ok) begin
            rec_wr_d                   = rec_wr_q + 1'b1;
            busy_d[bus.retire_rayID]   = 1'b0;
            pix_id_d                   = tbl_q[bus.retire_rayID];
        end

        case ({ret_ok, xfer && ~fresh})
            2'b10:   rec_cnt_d = rec_cnt_q + 1'b1;
            2'b01:   rec_cnt_d = rec_cnt_q - 1'b1;
            default: rec_cnt_d = rec_cnt_q;
        endcase

        case ({xfer, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase

        case ({xfer, ret_ok})
            2'b10:   nout_d = nout_q + 1'b1;
            2'b01:   nout_d = nout_q - 1'b1;
            default: nout_d = nout_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
            rec_rd_q   <= '0;
            rec_wr_q   <= '0;
            rec_cnt_q  <= '0;
            out_rd_q   <= '0;
            out_wr_q   <= '0;
            out_cnt_q  <= '0;
            busy_q     <= '0;
            nout_q     <= '0;
            err_q      <= 1'b0;
            pix_vld_q  <= 1'b0;
            pix_id_q   <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
            rec_rd_q   <= rec_rd_d;
            rec_wr_q   <= rec_wr_d;
            rec_cnt_q  <= rec_cnt_d;
            out_rd_q   <= out_rd_d;
            out_wr_q   <= out_wr_d;
            out_cnt_q  <= out_cnt_d;
            busy_q     <= busy_d;
            nout_q     <= nout_d;
            err_q      <= err_d;
            pix_vld_q  <= pix_vld_d;
            pix_id_q   <= pix_id_d;
        end
    end

    // Storage arrays carry data only; they need no reset because the
    // pointers and busy bits define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (xfer) begin
            tbl_q[alloc_id]     <= bus.prg_to_shader_data[GEOM_W+PIX_W-1:GEOM_W];
            out_mem_q[out_wr_q] <= {alloc_id, bus.prg_to_shader_data[GEOM_W-1:0]};
        end
        if (ret_ok) begin
            rec_mem_q[rec_wr_q] <= bus.retire_rayID;
        end
    end

    assign bus.prg_to_shader_stall = stall;
    assign bus.trav_valid          = (out_cnt_q != '0);
    assign bus.trav_data           = out_mem_q[out_rd_q];
    assign bus.pixel_valid         = pix_vld_q;
    assign bus.pixel_id            = pix_id_q;
    assign num_outstanding         = nout_q;
    assign err                     = err_q;

endmodule

// File: tb/tb_prg_ray_ingress.sv
// -----------------------------------------------------------------------------
// tb_prg_ray_ingress
// Bench for prg_ray_ingress. A negedge monitor keeps a behavioural model of the
// free list, busy bits, pixel table and output FIFO; expected trav_data words
// are queued when a transfer is driven and compared when the DUT pops them.
// The main process drives a vector table plus directed multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_prg_ray_ingress;
    localparam int NUM_RAYS  = 64;
    localparam int RID_W     = 6;
    localparam int PIX_W     = 19;
    localparam int OUT_DEPTH = 4;
    localparam int TW        = 192 + RID_W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [RID_W:0] num_outstanding;
    logic           err;

    prg_ray_ingress_if #(.RID_W(RID_W), .PIX_W(PIX_W)) bus ();

    prg_ray_ingress #(
        .NUM_RAYS(NUM_RAYS), .RID_W(RID_W), .PIX_W(PIX_W), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .num_outstanding(num_outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] rand_geom();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- reference model + scoreboard ----------------
    int               m_init;
    int               m_rec[$];
    bit               m_busy[NUM_RAYS];
    logic [PIX_W-1:0] m_tbl[NUM_RAYS];
    int               m_ocnt, m_nout, aid;
    bit               m_err, m_pv, ms, mpop, rok, rbad;
    logic [PIX_W-1:0] m_pid, rpix;
    logic [TW-1:0]    sbq[$];

    initial begin
        forever begin
            @(negedge clk);
            ms = ((m_init == NUM_RAYS) && (m_rec.size() == 0)) || (m_ocnt == OUT_DEPTH);
            if (chk_en) begin
                check("mon_stall", 256'(bus.prg_to_shader_stall), 256'(ms));
                check("mon_trav_valid", 256'(bus.trav_valid), 256'(m_ocnt != 0));
                check("mon_num_outstanding", 256'(num_outstanding), 256'(m_nout));
                check("mon_err", 256'(err), 256'(m_err));
                check("mon_pixel_valid", 256'(bus.pixel_valid), 256'(m_pv));
                if (m_pv) check("mon_pixel_id", 256'(bus.pixel_id), 256'(m_pid));
            end
            if (rst) begin
                m_init = 0;
                m_rec.delete();
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_ocnt = 0;
                m_nout = 0;
                m_err  = 1'b0;
                m_pv   = 1'b0;
                m_pid  = '0;
                sbq.delete();
            end else begin
                mpop = (m_ocnt != 0) && !bus.trav_stall;
                if (mpop && sbq.size() > 0) begin
                    if (chk_en) check("sb_trav_data", 256'(bus.trav_data), 256'(sbq[0]));
                    void'(sbq.pop_front());
                    m_ocnt--;
                end
                rok  = bus.retire_valid &&  m_busy[bus.retire_rayID];
                rbad = bus.retire_valid && !m_busy[bus.retire_rayID];
                rpix = m_tbl[bus.retire_rayID];
                if (bus.prg_to_shader_valid && !ms) begin
                    if (m_init < NUM_RAYS) begin
                        aid = m_init;
                        m_init++;
                    end else begin
                        aid = m_rec.pop_front();
                    end
                    m_tbl[aid]  = bus.prg_to_shader_data[210:192];
                    m_busy[aid] = 1'b1;
                    m_nout++;
                    m_ocnt++;
                    sbq.push_back({RID_W'(aid), bus.prg_to_shader_data[191:0]});
                end
                m_pv = rok;
                if (rok) begin
                    m_pid = rpix;
                    m_busy[bus.retire_rayID] = 1'b0;
                    m_rec.push_back(int'(bus.retire_rayID));
                    m_nout--;
                end
                if (rbad) m_err = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [PIX_W-1:0] pix;
        logic [191:0]     geom;
        logic [RID_W-1:0] rid;
    } vec_t;

    vec_t             vt[6];
    int               acc;
    logic [RID_W-1:0] r_ids[3];
    logic [PIX_W-1:0] r_pix[3];

    initial begin
        bus.prg_to_shader_valid = 1'b0;
        bus.prg_to_shader_data  = '0;
        bus.trav_stall          = 1'b0;
        bus.retire_valid        = 1'b0;
        bus.retire_rayID        = '0;

        vt[0] = '{19'd5,      rand_geom(), 6'd0};
        vt[1] = '{19'd6,      rand_geom(), 6'd1};
        vt[2] = '{19'd7,      rand_geom(), 6'd2};
        vt[3] = '{19'd307199, {192{1'b1}}, 6'd3};
        vt[4] = '{19'd0,      {96'h3F800000_BF800000_7F800000, 96'h00000000_80000000_7FC00000}, 6'd4};
        vt[5] = '{19'h7FFFF,  rand_geom(), 6'd5};

        repeat (3) cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_trav_valid", 256'(bus.trav_valid), 256'(0));
        check("rst_pixel_valid", 256'(bus.pixel_valid), 256'(0));
        check("rst_pixel_id", 256'(bus.pixel_id), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_num_outstanding", 256'(num_outstanding), 256'(0));
        check("rst_stall", 256'(bus.prg_to_shader_stall), 256'(0));

        // Back-to-back rays from the vector table
        for (int i = 0; i < 6; i++) begin
            bus.prg_to_shader_valid = 1'b1;
            bus.prg_to_shader_data  = {vt[i].pix, vt[i].geom};
            cyc();
            check("t1_trav_valid", 256'(bus.trav_valid), 256'(1));
            check("t1_rid", 256'(bus.trav_data[TW-1:192]), 256'(vt[i].rid));
            check("t1_geom", 256'(bus.trav_data[191:0]), 256'(vt[i].geom));
            check("t1_nout", 256'(num_outstanding), 256'(i + 1));
        end
        bus.prg_to_shader_valid = 1'b0;
        cyc();

        // Output FIFO fills while traversal stalls
        bus.trav_stall = 1'b1;
        bus.prg_to_shader_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.prg_to_shader_data = {19'(200 + i), rand_geom()};
            if (!bus.prg_to_shader_stall) acc++;
            cyc();
        end
        check("t2_accepted", 256'(acc), 256'(OUT_DEPTH));
        check("t2_stall_full", 256'(bus.prg_to_shader_stall), 256'(1));
        bus.prg_to_shader_valid = 1'b0;
        bus.trav_stall = 1'b0;
        check("t2_stall_before_pop", 256'(bus.prg_to_shader_stall), 256'(1));
        cyc();
        check("t2_stall_after_pop", 256'(bus.prg_to_shader_stall), 256'(0));
        repeat (4) cyc();
        check("t2_drained", 256'(bus.trav_valid), 256'(0));
        check("t2_nout", 256'(num_outstanding), 256'(10));

        // Exhaust the free list; IDs 10..63 get pixels 100..153
        bus.prg_to_shader_valid = 1'b1;
        for (int k = 0; k < 200 && !bus.prg_to_shader_stall; k++) begin
            bus.prg_to_shader_data = {19'(100 + k), rand_geom()};
            cyc();
        end
        bus.prg_to_shader_valid = 1'b0;
        check("t3_nout_full", 256'(num_outstanding), 256'(NUM_RAYS));
        repeat (4) cyc();
        check("t3_stall_empty_list", 256'(bus.prg_to_shader_stall), 256'(1));
        bus.retire_valid = 1'b1;
        bus.retire_rayID = 6'd17;
        check("t3_stall_retire_cycle", 256'(bus.prg_to_shader_stall), 256'(1));
        cyc();
        bus.retire_valid = 1'b0;
        check("t3_pixel_valid", 256'(bus.pixel_valid), 256'(1));
        check("t3_pixel_id", 256'(bus.pixel_id), 256'(107));
        check("t3_stall_relieved", 256'(bus.prg_to_shader_stall), 256'(0));
        bus.prg_to_shader_valid = 1'b1;
        bus.prg_to_shader_data  = {19'd500, rand_geom()};
        cyc();
        bus.prg_to_shader_valid = 1'b0;
        check("t3_rid_recycled", 256'(bus.trav_data[TW-1:192]), 256'(17));
        cyc();

        // Retire 3, 9, 4 back-to-back, then reallocate in retire order
        r_ids[0] = 6'd3; r_pix[0] = 19'd307199;
        r_ids[1] = 6'd9; r_pix[1] = 19'd203;
        r_ids[2] = 6'd4; r_pix[2] = 19'd0;
        for (int k = 0; k < 3; k++) begin
            bus.retire_valid = 1'b1;
            bus.retire_rayID = r_ids[k];
            cyc();
            check("t4_pixel_valid", 256'(bus.pixel_valid), 256'(1));
            check("t4_pixel_id", 256'(bus.pixel_id), 256'(r_pix[k]));
        end
        bus.retire_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.prg_to_shader_valid = 1'b1;
            bus.prg_to_shader_data  = {19'(600 + k), rand_geom()};
            cyc();
            check("t4_rid_order", 256'(bus.trav_data[TW-1:192]), 256'(r_ids[k]));
        end
        bus.prg_to_shader_valid = 1'b0;
        cyc();

        // Retire of a never-allocated ID
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.prg_to_shader_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.prg_to_shader_data = {19'(700 + k), rand_geom()};
            cyc();
        end
        bus.prg_to_shader_valid = 1'b0;
        bus.retire_valid = 1'b1;
        bus.retire_rayID = 6'd40;
        cyc();
        bus.retire_valid = 1'b0;
        check("t5_err_set", 256'(err), 256'(1));
        check("t5_no_pixel", 256'(bus.pixel_valid), 256'(0));
        repeat (3) cyc();
        check("t5_err_sticky", 256'(err), 256'(1));
        check("t5_nout", 256'(num_outstanding), 256'(10));
        bus.prg_to_shader_valid = 1'b1;
        bus.prg_to_shader_data  = {19'd800, rand_geom()};
        cyc();
        bus.prg_to_shader_valid = 1'b0;
        check("t5_next_rid", 256'(bus.trav_data[TW-1:192]), 256'(10));

        // Reset mid-stream with 20 outstanding and data queued
        bus.prg_to_shader_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.prg_to_shader_data = {19'(900 + k), rand_geom()};
            cyc();
        end
        check("t6_nout_before", 256'(num_outstanding), 256'(20));
        bus.trav_stall = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.trav_stall = 1'b0;
        check("t6_trav_valid", 256'(bus.trav_valid), 256'(0));
        check("t6_nout", 256'(num_outstanding), 256'(0));
        check("t6_err", 256'(err), 256'(0));
        check("t6_stall", 256'(bus.prg_to_shader_stall), 256'(0));
        bus.prg_to_shader_data = {19'd1000, rand_geom()};
        cyc();
        bus.prg_to_shader_valid = 1'b0;
        check("t6_first_rid", 256'(bus.trav_data[TW-1:192]), 256'(0));
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prg_ray_ingress.md
Name: prg_ray_ingress

Overview:
- Shader-side receiver for primary rays from the primary ray generator, over the prg_to_shader valid/stall interface.
- Allocates a ray ID from a free list for each ray and records its pixel ID in a ray-info table indexed by ray ID.
- Forwards {rayID, origin, dir} through a small output FIFO to traversal.
- On ray retirement, returns the pixel ID and recycles the ray ID.

Parameters:
- NUM_RAYS, 64, number of ray IDs in flight; power of two.
- RID_W, $clog2(NUM_RAYS), ray ID width.
- PIX_W, 19, pixel ID width (640x480 linear index).
- OUT_DEPTH, 4, output FIFO depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- prg_to_shader_valid  in  1  upstream ray available.
- prg_to_shader_data  in  211  prg_ray_t: [210:192] pixelID, [191:96] origin xyz, [95:0] dir xyz (IEEE single floats).
- prg_to_shader_stall  out  1  upstream must hold data.
- trav_valid  out  1  output ray available.
- trav_data  out  192+RID_W  {rayID, origin, dir}.
- trav_stall  in  1  downstream stall.
- retire_valid  in  1  ray finished.
- retire_rayID  in  RID_W  ID being retired.
- pixel_valid  out  1  pixel lookup result valid.
- pixel_id  out  PIX_W  pixel of retired ray.
- num_outstanding  out  RID_W+1  IDs currently allocated.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Upstream transfer occurs in a cycle where prg_to_shader_valid && !prg_to_shader_stall.
- prg_to_shader_stall = free_list_empty || (out_count == OUT_DEPTH). It is a function of registered state only: no combinational path from any input.
- On transfer:
  - Pop the head ray ID.
  - Write table[rayID] <= pixelID.
  - Push {rayID, origin, dir} into the output FIFO, visible at trav_valid the next cycle.
  - Set the outstanding bit for that ID.
- Free-list allocation order:
  - After reset, fresh IDs are issued in order 0,1,…,NUM_RAYS-1 via an init counter.
  - Once the init counter is exhausted, recycled IDs are issued from a NUM_RAYS-deep recycle FIFO in retire order.
  - A fresh ID is always chosen over a recycled one while the init counter is not exhausted.
- Output side:
  - trav_valid = out FIFO not empty. trav_data is the FIFO head.
  - The head is popped when trav_valid && !trav_stall.
  - Simultaneous push and pop keeps out_count unchanged.
  - A full FIFO with a same-cycle pop still stalls upstream, because stall uses registered state.
- Retire:
  - retire_valid at cycle t produces pixel_valid=1 and pixel_id=table[retire_rayID] at t+1, and the ID is pushed to the recycle FIFO at t+1.
  - The recycled ID is allocatable from cycle t+1.
  - A retire in the same cycle as an allocation with an empty free list does not relieve stall in that cycle.
- Retire of an ID whose outstanding bit is clear:
  - Set err (sticky until rst), suppress pixel_valid, do not push the ID.
- num_outstanding increments on allocation and decrements on valid retire. Both events in one cycle leave it unchanged.
- Reset values:
  - trav_valid=0, pixel_valid=0, pixel_id=0, err=0, num_outstanding=0.
  - prg_to_shader_stall=0 (free list full, FIFO empty).
  - Init counter=0, recycle FIFO empty, all outstanding bits clear.
  - Table contents are not reset.
- Reset mid-operation:
  - All in-flight IDs are discarded.
  - The next allocation is ID 0.
  - Output FIFO contents are dropped.
- Latency: upstream transfer to trav_valid is 1 cycle. Retire to pixel_valid is 1 cycle.

Test Plan:
- Reset, then 3 back-to-back rays with pixelIDs 5,6,7 and trav_stall=0 -> trav_data rayIDs 0,1,2 on cycles 1,2,3; origin and dir unchanged; num_outstanding=3.
- trav_stall=1 held and rays streamed -> exactly 4 transfers accepted, then prg_to_shader_stall=1; release -> FIFO drains in order, stall drops the cycle after the first pop.
- Allocate all 64 IDs with no retires -> stall=1. Retire ID 17 -> pixel_valid next cycle with its pixelID; next accepted ray gets rayID 17.
- Retire IDs 3, 9, 4 in consecutive cycles after full allocation -> pixel_ids match the stored values; subsequent allocations are 3, 9, 4.
- Retire a never-allocated ID (e.g. 40 after only 10 allocations) -> err=1 stays high, pixel_valid=0, next allocation is 10.
- Assert rst mid-stream with 20 outstanding -> next cycle trav_valid=0, num_outstanding=0, err=0; first new ray gets rayID 0.
